// File: rtl/gpo_pad_ctrl.sv
// gpo_pad_ctrl: drives one general-purpose output pad with glitch-free config changes
// and bias-gated drive strength.
module gpo_pad_ctrl #(
    parameter int SETTLE_CYC  = 8,
    parameter int BIAS_TO_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [1:0] cfg_ds_i,
    input  logic       cfg_sr_i,
    input  logic       cfg_co_i,
    input  logic [1:0] cfg_mode_i,
    input  logic       data_i,
    input  logic       oe_req_i,
    input  logic       bias_ok_i,
    input  logic       err_clr_i,
    output logic       bias_req_o,
    output logic       do_o,
    output logic [1:0] ds_o,
    output logic       sr_o,
    output logic       co_o,
    output logic       oe_o,
    output logic       odp_o,
    output logic       odn_o,
    output logic       busy_o,
    output logic       err_bias_o
);
    localparam int CNT_MAX = (SETTLE_CYC > BIAS_TO_CYC) ? SETTLE_CYC : BIAS_TO_CYC;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BIAS_TO_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

    typedef enum logic [2:0] {ACTIVE, QUIESCE, APPLY, WAIT_BIAS, SETTLE} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [5:0]             pend_q, pend_d;
    logic [1:0]             ds_q, ds_d, mode_q, mode_d;
    logic                   sr_q, sr_d, co_q, co_d, oe_q, oe_d, odp_q, odp_d, odn_q, odn_d;
    logic                   bias_req_q, bias_req_d, err_q, err_d, busy_q, busy_d;
    logic                   ready_q, ready_d, do_q, err_set, bias_s, xfer;

    assign bias_s = sync_q[SYNC_STAGES-1];
    assign xfer   = cfg_valid_i & ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        pend_d     = pend_q;
        ds_d       = ds_q;
        sr_d       = sr_q;
        co_d       = co_q;
        mode_d     = mode_q;
        bias_req_d = bias_req_q;
        err_set    = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (ds_q != 2'b00 && !bias_s) begin
                    state_d    = SETTLE;
                    ds_d       = 2'b00;
                    bias_req_d = 1'b0;
                    err_set    = 1'b1;
                end else if (xfer) begin
                    state_d = QUIESCE;
                    pend_d  = {cfg_ds_i, cfg_sr_i, cfg_co_i, cfg_mode_i};
                end
            end
            QUIESCE: state_d = (cnt_q == SETTLE_LAST) ? APPLY : QUIESCE;
            APPLY: begin
                {ds_d, sr_d, co_d, mode_d} = pend_q;
                bias_req_d = |pend_q[5:4];
                state_d    = bias_req_d ? WAIT_BIAS : SETTLE;
            end
            WAIT_BIAS: begin
                if (bias_s) begin
                    state_d = SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = SETTLE;
                    ds_d       = 2'b00;
                    bias_req_d = 1'b0;
                    err_set    = 1'b1;
                end
            end
            SETTLE:  state_d = (cnt_q == SETTLE_LAST) ? ACTIVE : SETTLE;
            default: state_d = ACTIVE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        err_d   = err_set | (err_q & ~err_clr_i);
        oe_d    = (state_d == ACTIVE) & oe_req_i & (mode_d != 2'b11);
        odp_d   = (mode_d == 2'b01);
        odn_d   = (mode_d == 2'b10);
        busy_d  = (state_d != ACTIVE);
        // Look one sync stage ahead so ready drops in the same cycle a bias loss becomes visible.
        ready_d = (state_d == ACTIVE) & ~((ds_d != 2'b00) & ~sync_q[SYNC_STAGES-2]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ACTIVE;
            cnt_q      <= '0;
            sync_q     <= '0;
            pend_q     <= '0;
            ds_q       <= '0;
            mode_q     <= '0;
            sr_q       <= 1'b0;
            co_q       <= 1'b0;
            oe_q       <= 1'b0;
            odp_q      <= 1'b0;
            odn_q      <= 1'b0;
            bias_req_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            do_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bias_ok_i};
            pend_q     <= pend_d;
            ds_q       <= ds_d;
            mode_q     <= mode_d;
            sr_q       <= sr_d;
            co_q       <= co_d;
            oe_q       <= oe_d;
            odp_q      <= odp_d;
            odn_q      <= odn_d;
            bias_req_q <= bias_req_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            do_q       <= data_i;
        end
    end

    assign cfg_ready_o = ready_q;
    assign bias_req_o  = bias_req_q;
    assign do_o        = do_q;
    assign ds_o        = ds_q;
    assign sr_o        = sr_q;
    assign co_o        = co_q;
    assign oe_o        = oe_q;
    assign odp_o       = odp_q;
    assign odn_o       = odn_q;
    assign busy_o      = busy_q;
    assign err_bias_o  = err_q;
endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// tb_gpo_pad_ctrl: directed checks of gpo_pad_ctrl with SETTLE_CYC=8, BIAS_TO_CYC=16.
module tb_gpo_pad_ctrl;
    logic       clk_i = 1'b0, rst_ni = 1'b0;
    logic       cfg_valid_i = 1'b0, cfg_ready_o;
    logic [1:0] cfg_ds_i = 2'b00, cfg_mode_i = 2'b00, ds_o;
    logic       cfg_sr_i = 1'b0, cfg_co_i = 1'b0, data_i = 1'b0, oe_req_i = 1'b0;
    logic       bias_ok_i = 1'b0, err_clr_i = 1'b0;
    logic       bias_req_o, do_o, sr_o, co_o, oe_o, odp_o, odn_o, busy_o, err_bias_o;
    int         n_cmp = 0, n_bad = 0;

    gpo_pad_ctrl #(.SETTLE_CYC(8), .BIAS_TO_CYC(16), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_ds_i(cfg_ds_i), .cfg_sr_i(cfg_sr_i), .cfg_co_i(cfg_co_i), .cfg_mode_i(cfg_mode_i),
        .data_i(data_i), .oe_req_i(oe_req_i), .bias_ok_i(bias_ok_i), .err_clr_i(err_clr_i),
        .bias_req_o(bias_req_o), .do_o(do_o), .ds_o(ds_o), .sr_o(sr_o), .co_o(co_o),
        .oe_o(oe_o), .odp_o(odp_o), .odn_o(odn_o), .busy_o(busy_o), .err_bias_o(err_bias_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs every pad-facing output so one comparison covers the whole pin set.
    function automatic logic [7:0] pins();
        return {ds_o, sr_o, co_o, oe_o, odp_o, odn_o, do_o};
    endfunction

    initial begin
        tick();
        chk("rst_pins", pins(), 8'h00);
        chk("rst_ready", {cfg_ready_o, busy_o, bias_req_o, err_bias_o}, 8'h0);
        rst_ni = 1'b1;
        tick();
        chk("ready_after_rst", cfg_ready_o, 1'b1);
        data_i = 1'b1; oe_req_i = 1'b1;
        tick();
        chk("oe_do_on", pins(), 8'b00_0_0_1_0_0_1);
        data_i = 1'b0;
        tick();
        chk("do_follows", pins(), 8'b00_0_0_1_0_0_0);

        cfg_valid_i = 1'b1; cfg_ds_i = 2'b00; cfg_mode_i = 2'b01; cfg_sr_i = 1'b1; cfg_co_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            chk($sformatf("seq_oe_low_%0d", i), {oe_o, cfg_ready_o, busy_o}, 3'b001);
            if (i == 9) chk("odp_not_yet", odp_o, 1'b0);
            if (i == 10) chk("odp_applied", {odp_o, odn_o, sr_o, co_o}, 4'b1011);
            tick();
        end
        chk("seq_oe_back", {oe_o, cfg_ready_o, busy_o, ds_o, bias_req_o}, 6'b110_00_0);

        cfg_valid_i = 1'b1; cfg_ds_i = 2'b10; cfg_mode_i = 2'b00; cfg_sr_i = 1'b0; cfg_co_i = 1'b0;
        tick();
        cfg_valid_i = 1'b0;
        tick(9);
        chk("wb_entry", {ds_o, bias_req_o, oe_o, busy_o, odp_o}, 6'b10_1_0_1_0);
        tick(10);
        chk("wb_hold", {ds_o, bias_req_o, err_bias_o}, 4'b10_1_0);
        bias_ok_i = 1'b1;
        tick(10);
        chk("wb_settle_last", {oe_o, busy_o}, 2'b01);
        tick();
        chk("wb_active", {oe_o, busy_o, cfg_ready_o, ds_o, bias_req_o, err_bias_o}, 7'b1_0_1_10_1_0);

        bias_ok_i = 1'b0;
        tick();
        chk("loss_sync1", {oe_o, cfg_ready_o}, 2'b11);
        tick();
        chk("loss_ready_drop", {oe_o, cfg_ready_o}, 2'b10);
        cfg_valid_i = 1'b1; cfg_ds_i = 2'b01; cfg_mode_i = 2'b11;
        tick();
        cfg_valid_i = 1'b0;
        chk("loss_forced", {oe_o, ds_o, bias_req_o, err_bias_o, busy_o}, 6'b0_00_0_1_1);
        tick(7);
        chk("loss_settle", busy_o, 1'b1);
        tick();
        chk("loss_no_xfer", {busy_o, oe_o, ds_o, cfg_ready_o, err_bias_o}, 6'b0_1_00_1_1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_clr_1", err_bias_o, 1'b0);

        cfg_valid_i = 1'b1; cfg_ds_i = 2'b11; cfg_mode_i = 2'b10; cfg_sr_i = 1'b1; cfg_co_i = 1'b0;
        tick();
        cfg_valid_i = 1'b0;
        tick(9);
        chk("to_entry", {ds_o, bias_req_o, odp_o, odn_o, sr_o, co_o}, 7'b11_1_0_1_1_0);
        tick(15);
        chk("to_before", {err_bias_o, ds_o, bias_req_o}, 4'b0_11_1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("to_fire_set_wins", {err_bias_o, ds_o, bias_req_o, busy_o, oe_o}, 6'b1_00_0_1_0);
        tick(7);
        chk("to_settle", busy_o, 1'b1);
        tick();
        chk("to_active", {busy_o, oe_o, err_bias_o, ds_o}, 5'b0_1_1_00);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_clr_2", err_bias_o, 1'b0);

        data_i = 1'b1;
        cfg_valid_i = 1'b1; cfg_ds_i = 2'b01; cfg_mode_i = 2'b01;
        tick();
        cfg_valid_i = 1'b0;
        tick(9);
        chk("rst_mid_wb", {bias_req_o, ds_o, do_o, busy_o}, 5'b1_01_1_1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_pins", pins(), 8'h00);
        chk("rst_async_ctl", {cfg_ready_o, busy_o, bias_req_o, err_bias_o}, 8'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rst_release", {cfg_ready_o, busy_o, ds_o, oe_o, odp_o}, 6'b1_0_00_1_0);
        tick(12);
        chk("rst_pend_gone", {busy_o, ds_o, bias_req_o, odp_o}, 5'b0_00_0_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
